// File: rtl/zero_flag_pipe_if.sv
// Handshake bundle between the EX stage and the zero/flag pipe.
// The master drives the ALU result and pipeline control; the slave returns the result and the flags.
interface zero_flag_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_c;
  logic             in_v;
  logic             in_set;
  logic             stall;
  logic             flush;
  logic             res_valid;
  logic             zero;
  logic             negative;
  logic [3:0]       flags;

  modport master (
    output in_valid, in_data, in_c, in_v, in_set, stall, flush,
    input  res_valid, zero, negative, flags
  );

  modport slave (
    input  in_valid, in_data, in_c, in_v, in_set, stall, flush,
    output res_valid, zero, negative, flags
  );
endinterface

// File: rtl/zero_flag_pipe.sv
// Two-stage zero/negative detector with an NZCV flag register at the EX/MEM boundary.
// S1 holds first-level NOR groups; S2 finishes the reduction and drives the registered flags.
module zero_flag_pipe #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  zero_flag_pipe_if.slave  bus
);

  localparam int NGRP = WIDTH / GROUP;

  if (((WIDTH % GROUP) != 0) || (GROUP < 2) || (GROUP > 8)) begin : g_bad_params
    $error("zero_flag_pipe: WIDTH must be a multiple of GROUP and GROUP must be in 2..8");
  end

  // First-level reduction: one bit per GROUP-wide slice, set when the slice is all zero.
  function automatic logic [NGRP-1:0] group_nor(input logic [WIDTH-1:0] data);
    logic [NGRP-1:0] grp;
    grp = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp[k] = ~|data[k*GROUP +: GROUP];
    end
    return grp;
  endfunction

  logic            s1_valid_r;
  logic [NGRP-1:0] s1_nor_r;
  logic            s1_msb_r;
  logic            s1_c_r;
  logic            s1_v_r;
  logic            s1_set_r;
  logic            s2_valid_r;
  logic            s2_zero_r;
  logic            s2_neg_r;
  logic [3:0]      flags_r;

  logic            kill_s;
  logic            advance_s;
  logic            s1_zero_s;
  logic            flag_we_s;

  logic            s1_valid_s;
  logic [NGRP-1:0] s1_nor_s;
  logic            s1_msb_s;
  logic            s1_c_s;
  logic            s1_v_s;
  logic            s1_set_s;
  logic            s2_valid_s;
  logic            s2_zero_s;
  logic            s2_neg_s;
  logic [3:0]      flags_s;

  // Pipeline control: flush wins over stall, and neither lets the stages advance.
  always_comb begin
    kill_s    = 1'b0;
    advance_s = 1'b0;
    if (bus.flush) begin
      kill_s = 1'b1;
    end else if (!bus.stall) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
    s1_zero_s = &s1_nor_r;
    flag_we_s = advance_s & s1_valid_r & s1_set_r;
  end

  // Next-state for both stages and the flag register.
  always_comb begin
    s1_valid_s = s1_valid_r;
    s1_nor_s   = s1_nor_r;
    s1_msb_s   = s1_msb_r;
    s1_c_s     = s1_c_r;
    s1_v_s     = s1_v_r;
    s1_set_s   = s1_set_r;
    s2_valid_s = s2_valid_r;
    s2_zero_s  = s2_zero_r;
    s2_neg_s   = s2_neg_r;
    flags_s    = flags_r;

    if (kill_s) begin
      s1_valid_s = 1'b0;
      s2_valid_s = 1'b0;
    end else if (advance_s) begin
      s1_valid_s = bus.in_valid;
      s1_nor_s   = group_nor(bus.in_data);
      s1_msb_s   = bus.in_data[WIDTH-1];
      s1_c_s     = bus.in_c;
      s1_v_s     = bus.in_v;
      s1_set_s   = bus.in_set;
      s2_valid_s = s1_valid_r;
      s2_zero_s  = s1_zero_s;
      s2_neg_s   = s1_msb_r;
    end else begin
      s1_valid_s = s1_valid_r;
      s2_valid_s = s2_valid_r;
    end

    if (flag_we_s) begin
      flags_s = {s1_msb_r, s1_zero_s, s1_c_r, s1_v_r};
    end else begin
      flags_s = flags_r;
    end
  end

  // State registers; reset clears every valid bit, result and the flags immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_nor_r   <= '0;
      s1_msb_r   <= 1'b0;
      s1_c_r     <= 1'b0;
      s1_v_r     <= 1'b0;
      s1_set_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_neg_r   <= 1'b0;
      flags_r    <= 4'b0000;
    end else begin
      s1_valid_r <= s1_valid_s;
      s1_nor_r   <= s1_nor_s;
      s1_msb_r   <= s1_msb_s;
      s1_c_r     <= s1_c_s;
      s1_v_r     <= s1_v_s;
      s1_set_r   <= s1_set_s;
      s2_valid_r <= s2_valid_s;
      s2_zero_r  <= s2_zero_s;
      s2_neg_r   <= s2_neg_s;
      flags_r    <= flags_s;
    end
  end

  assign bus.res_valid = s2_valid_r;
  assign bus.zero      = s2_zero_r;
  assign bus.negative  = s2_neg_r;
  assign bus.flags     = flags_r;

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Directed bench for zero_flag_pipe: default 64/4 instance plus 32/8 and 64/2 instances
// that replay the basic zero-with-flags entry.
module tb_zero_flag_pipe;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  zero_flag_pipe_if #(.WIDTH(64)) b ();
  zero_flag_pipe_if #(.WIDTH(32)) b32 ();
  zero_flag_pipe_if #(.WIDTH(64)) b2 ();

  zero_flag_pipe #(.WIDTH(64), .GROUP(4)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  zero_flag_pipe #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  zero_flag_pipe #(.WIDTH(64), .GROUP(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic vld, input logic [63:0] d, input logic c, input logic v, input logic s);
    b.in_valid = vld;
    b.in_data  = d;
    b.in_c     = c;
    b.in_v     = v;
    b.in_set   = s;
  endtask

  task automatic chk_main(input string tag, input logic rv, input logic z, input logic n, input logic [3:0] f);
    check_eq({tag, ".res_valid"}, {63'd0, b.res_valid}, {63'd0, rv});
    if (rv) begin
      check_eq({tag, ".zero"}, {63'd0, b.zero}, {63'd0, z});
      check_eq({tag, ".negative"}, {63'd0, b.negative}, {63'd0, n});
    end
    check_eq({tag, ".flags"}, {60'd0, b.flags}, {60'd0, f});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    b.stall = 1'b0;  b.flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_data = 32'd0; b32.in_c = 1'b0; b32.in_v = 1'b0;
    b32.in_set = 1'b0;   b32.stall = 1'b0;    b32.flush = 1'b0;
    b2.in_valid = 1'b0;  b2.in_data = 64'd0;  b2.in_c = 1'b0;  b2.in_v = 1'b0;
    b2.in_set = 1'b0;    b2.stall = 1'b0;     b2.flush = 1'b0;

    repeat (2) @(negedge clk);
    chk_main("reset", 1'b0, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;
    step();
    chk_main("post_reset", 1'b0, 1'b0, 1'b0, 4'b0000);

    // Zero entry with S bit, carry set: all three geometries.
    put(1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
    b32.in_valid = 1'b1; b32.in_data = 32'd0; b32.in_c = 1'b1; b32.in_v = 1'b0; b32.in_set = 1'b1;
    b2.in_valid = 1'b1;  b2.in_data = 64'd0;  b2.in_c = 1'b1;  b2.in_v = 1'b0;  b2.in_set = 1'b1;
    step();
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    b32.in_valid = 1'b0; b32.in_set = 1'b0;
    b2.in_valid = 1'b0;  b2.in_set = 1'b0;
    chk_main("zero.t1", 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    chk_main("zero.t2", 1'b1, 1'b1, 1'b0, 4'b0110);
    check_eq("w32.res_valid", {63'd0, b32.res_valid}, 64'd1);
    check_eq("w32.zero", {63'd0, b32.zero}, 64'd1);
    check_eq("w32.negative", {63'd0, b32.negative}, 64'd0);
    check_eq("w32.flags", {60'd0, b32.flags}, 64'h6);
    check_eq("g2.res_valid", {63'd0, b2.res_valid}, 64'd1);
    check_eq("g2.zero", {63'd0, b2.zero}, 64'd1);
    check_eq("g2.negative", {63'd0, b2.negative}, 64'd0);
    check_eq("g2.flags", {60'd0, b2.flags}, 64'h6);
    step();
    chk_main("zero.t3", 1'b0, 1'b0, 1'b0, 4'b0110);

    // Walking single one, back to back, no flag updates.
    for (int j = 0; j < 66; j++) begin
      if (j >= 2) begin
        chk_main($sformatf("walk%0d", j - 2), 1'b1, 1'b0, (j - 2) == 63, 4'b0110);
      end
      if (j < 64) begin
        put(1'b1, 64'd1 << j, 1'b0, 1'b0, 1'b0);
      end else begin
        put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      end
      step();
    end
    chk_main("walk.end", 1'b0, 1'b0, 1'b0, 4'b0110);

    // Flag-setting entry followed by a non-setting one.
    put(1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b1);
    step();
    put(1'b1, 64'd0, 1'b1, 1'b1, 1'b0);
    step();
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk_main("setA", 1'b1, 1'b0, 1'b1, 4'b1001);
    step();
    chk_main("noset", 1'b1, 1'b1, 1'b0, 4'b1001);

    // Stall for three cycles with two entries in flight.
    put(1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
    step();
    put(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    step();
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk_main("stall.pre", 1'b1, 1'b1, 1'b0, 4'b0100);
    b.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_main($sformatf("stall%0d", k), 1'b1, 1'b1, 1'b0, 4'b0100);
    end
    b.stall = 1'b0;
    step();
    chk_main("stall.rel1", 1'b1, 1'b0, 1'b1, 4'b1011);
    step();
    chk_main("stall.rel2", 1'b0, 1'b0, 1'b0, 4'b1011);

    // Flush with stall while a flagging entry sits in S1.
    put(1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
    step();
    put(1'b1, 64'd0, 1'b1, 1'b1, 1'b1);
    step();
    chk_main("flush.pre", 1'b1, 1'b0, 1'b0, 4'b1011);
    put(1'b1, 64'd0, 1'b0, 1'b0, 1'b1);
    b.stall = 1'b1;
    b.flush = 1'b1;
    step();
    b.stall = 1'b0;
    b.flush = 1'b0;
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk_main("flush.t1", 1'b0, 1'b0, 1'b0, 4'b1011);
    step();
    chk_main("flush.t2", 1'b0, 1'b0, 1'b0, 4'b1011);
    step();
    chk_main("flush.t3", 1'b0, 1'b0, 1'b0, 4'b1011);

    // Asynchronous reset between clock edges with entries in flight.
    put(1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
    step();
    put(1'b1, 64'd2, 1'b0, 1'b0, 1'b1);
    step();
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk_main("arst.pre", 1'b1, 1'b1, 1'b0, 4'b0110);
    #2;
    reset = 1'b1;
    #1;
    chk_main("arst.now", 1'b0, 1'b0, 1'b0, 4'b0000);
    check_eq("arst.zero", {63'd0, b.zero}, 64'd0);
    check_eq("arst.negative", {63'd0, b.negative}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk_main("arst.after", 1'b0, 1'b0, 1'b0, 4'b0000);
    put(1'b1, 64'd4, 1'b1, 1'b0, 1'b1);
    step();
    put(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk_main("arst.new1", 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    chk_main("arst.new2", 1'b1, 1'b0, 1'b0, 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
